// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: FSM driving the J/K inputs of an external flip-flop bank
// to count it up/down to a limit, load it, or zero it.
module jk_bank_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             stop,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   steps
);
    typedef enum logic [2:0] {IDLE, RUN, LOAD, ZERO, DONE} state_t;
    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] load_q, load_d, limit_q, limit_d, tog;
    logic [WIDTH:0]   steps_q, steps_d;
    logic             busy_q, busy_d, done_q, done_d, carry;
    // bit i toggles when every lower bit is 1 (up) or 0 (down, mode_q[0]=1)
    always_comb begin
        carry = 1'b1;
        tog = '0;
        for (int i = 0; i < WIDTH; i++) begin
            tog[i] = carry;
            carry = carry & (q_fb[i] ^ mode_q[0]);
        end
    end
    always_comb begin
        state_d = state_q;
        mode_d = mode_q;
        load_d = load_q;
        limit_d = limit_q;
        steps_d = steps_q;
        j = '0;
        k = '0;
        case (state_q)
            IDLE: if (start) begin
                mode_d = mode;
                load_d = load_val;
                limit_d = limit;
                steps_d = '0;
                state_d = mode[1] ? (mode[0] ? ZERO : LOAD) : RUN;
            end
            RUN: if (q_fb == limit_q || stop) begin
                state_d = DONE;
            end else begin
                j = tog;
                k = tog;
                steps_d = steps_q + (WIDTH+1)'(1);
            end
            LOAD: begin
                j = load_q;
                k = ~load_q;
                state_d = DONE;
            end
            ZERO: begin
                k = '1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            mode_q <= '0;
            load_q <= '0;
            limit_q <= '0;
            steps_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q <= mode_d;
            load_q <= load_d;
            limit_q <= limit_d;
            steps_q <= steps_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign steps = steps_q;
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb_jk_bank_sequencer: drives jk_bank_sequencer against a behavioural JK bank
// and checks commands against an arithmetic count/load/zero model.
module tb_jk_bank_sequencer;
    localparam int W = 4;
    logic clk = 1'b0;
    logic clear, start, stop, busy, done, pre;
    logic [1:0] mode;
    logic [W-1:0] load_val, limit, q_fb, j, k, bank, pre_val;
    logic [W:0] steps;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    assign q_fb = bank;
    always_ff @(posedge clk) bank <= pre ? pre_val : (j & ~bank) | (~k & bank);

    jk_bank_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .clear(clear), .start(start), .mode(mode), .load_val(load_val),
        .limit(limit), .stop(stop), .q_fb(q_fb), .j(j), .k(k), .busy(busy),
        .done(done), .steps(steps)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input int v);
        pre = 1'b1;
        pre_val = v[W-1:0];
        tick();
        pre = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00;
        load_val = '0; limit = '0; pre = 1'b1; pre_val = '0;
        tick();
        pre = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_flags busy=%b done=%b want 0 0", busy, done); end
        n_cmp++; if (steps !== 0) begin n_err++; $display("FAIL reset_steps got %0d want 0", steps); end
        n_cmp++; if (j !== 0 || k !== 0) begin n_err++; $display("FAIL reset_jk j=%b k=%b want 0 0", j, k); end
        clear = 1'b0;
    endtask

    // init < 0 keeps the current bank value; stop_at < 0 never raises stop
    task automatic do_cmd(input string name, input logic [1:0] m, input logic [W-1:0] lv,
                          input logic [W-1:0] lim, input int init, input int stop_at);
        int b0, cur, n, fin, exp_edge, got, exp_b;
        if (init >= 0) preset(init);
        b0 = int'(bank);
        cur = b0;
        n = 0;
        if (!m[1]) begin
            while (cur != int'(lim) && cur != stop_at) begin
                cur = m[0] ? (cur + 15) % 16 : (cur + 1) % 16;
                n++;
            end
        end
        fin = (m == 2'b10) ? int'(lv) : (m == 2'b11) ? 0 : cur;
        exp_edge = m[1] ? 1 : n + 1;
        start = 1'b1; mode = m; load_val = lv; limit = lim;
        tick();
        mode = 2'($urandom); load_val = W'($urandom); limit = W'($urandom);
        if (m == 2'b10) begin
            n_cmp++; if (j !== lv || k !== ~lv) begin n_err++; $display("FAIL %s load_jk j=%b k=%b want %b %b", name, j, k, lv, ~lv); end
        end
        if (m == 2'b11) begin
            n_cmp++; if (j !== 0 || k !== '1) begin n_err++; $display("FAIL %s zero_jk j=%b k=%b want 0000 1111", name, j, k); end
        end
        got = -1;
        for (int e = 0; e <= 40; e++) begin
            if (done) begin
                got = e;
                break;
            end
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy at edge %0d got %b want 1", name, e, busy); end
            exp_b = m[0] ? (b0 - e + 32) % 16 : (b0 + e) % 16;
            if (!m[1] && e <= n) begin
                n_cmp++; if (int'(bank) != exp_b) begin n_err++; $display("FAIL %s bank at edge %0d got %0d want %0d", name, e, bank, exp_b); end
            end
            stop = !m[1] && int'(bank) == stop_at;
            if (stop) begin
                #1;
                n_cmp++; if (j !== 0 || k !== 0) begin n_err++; $display("FAIL %s stop_jk j=%b k=%b want 0 0", name, j, k); end
            end
            start = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        stop = 1'b0;
        n_cmp++; if (got != exp_edge) begin n_err++; $display("FAIL %s done_edge got %0d want %0d", name, got, exp_edge); end
        n_cmp++; if (int'(bank) != fin) begin n_err++; $display("FAIL %s bank_final got %0d want %0d", name, bank, fin); end
        n_cmp++; if (steps !== n) begin n_err++; $display("FAIL %s steps got %0d want %0d", name, steps, n); end
        tick();
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL %s after_done done=%b busy=%b want 0 0", name, done, busy); end
        n_cmp++; if (steps !== n || int'(bank) != fin) begin n_err++; $display("FAIL %s hold steps=%0d bank=%0d want %0d %0d", name, steps, bank, n, fin); end
    endtask

    task automatic test_directed();
        do_cmd("up_3_to_7", 2'b00, 4'h0, 4'd7, 3, -1);
        do_cmd("down_wrap", 2'b01, 4'h0, 4'd14, 1, -1);
        do_cmd("load_a", 2'b10, 4'hA, 4'h0, 5, -1);
        do_cmd("limit_eq", 2'b00, 4'h0, 4'd5, 5, -1);
        do_cmd("stop_at_6", 2'b00, 4'h0, 4'd15, 0, 6);
        do_cmd("zero", 2'b11, 4'h3, 4'h0, 9, -1);
        do_cmd("up_wrap", 2'b00, 4'h0, 4'd2, 14, -1);
    endtask

    task automatic test_back_to_back();
        do_cmd("b2b_a", 2'b00, 4'h0, 4'd9, 2, -1);
        do_cmd("b2b_b", 2'b01, 4'h0, 4'd4, -1, -1);
        do_cmd("b2b_c", 2'b10, 4'h5, 4'h0, -1, -1);
        do_cmd("b2b_d", 2'b00, 4'h0, 4'd5, -1, -1);
    endtask

    task automatic test_clear_mid_run();
        int hold;
        preset(0);
        start = 1'b1; mode = 2'b00; limit = 4'd15;
        tick();
        start = 1'b0;
        repeat (3) tick();
        clear = 1'b1; start = 1'b1;
        tick();
        clear = 1'b0; start = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL clear_run flags busy=%b done=%b want 0 0", busy, done); end
        n_cmp++; if (steps !== 0) begin n_err++; $display("FAIL clear_run steps got %0d want 0", steps); end
        n_cmp++; if (j !== 0 || k !== 0) begin n_err++; $display("FAIL clear_run jk j=%b k=%b want 0 0", j, k); end
        n_cmp++; if (bank !== 4'd4) begin n_err++; $display("FAIL clear_run bank got %0d want 4", bank); end
        hold = int'(bank);
        repeat (6) begin
            tick();
            n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || int'(bank) != hold) begin n_err++; $display("FAIL clear_run idle done=%b busy=%b bank=%0d want 0 0 %0d", done, busy, bank, hold); end
        end
    endtask

    task automatic test_random();
        int sa;
        for (int r = 0; r < 30; r++) begin
            sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1;
            do_cmd("random", 2'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 15)), sa);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_clear_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/jk_bank_sequencer.md
JK_BANK_SEQUENCER -- requirements
Module: jk_bank_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, number of external JK flip-flops in the controlled bank.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: clear  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: start  input  1  command request; sampled only in IDLE.
REQ-005 SHALL have port: mode  input  2  command: 00 count up, 01 count down, 10 load, 11 zero.
REQ-006 SHALL have port: load_val  input  WIDTH  value written to the bank by the load command.
REQ-007 SHALL have port: limit  input  WIDTH  terminal value for count commands.
REQ-008 SHALL have port: stop  input  1  abort request for a running count.
REQ-009 SHALL have port: q_fb  input  WIDTH  q outputs of the bank, fed back.
REQ-010 SHALL have port: j  output  WIDTH  J inputs of the bank, one per bit.
REQ-011 SHALL have port: k  output  WIDTH  K inputs of the bank, one per bit.
REQ-012 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port: steps  output  WIDTH+1  number of count steps in the last command.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, LOAD, ZERO and DONE.
REQ-016 SHALL drive j and k combinationally from the current state, the captured registers and q_fb, so the bank updates on the same clock edge as the FSM.
REQ-017 SHALL, in IDLE with start=1, capture mode, load_val and limit into internal registers.
REQ-018 SHALL, on that same IDLE start=1 edge, clear steps to 0.
REQ-019 SHALL, on that same IDLE start=1 edge, go to RUN for mode 00/01, LOAD for 10, or ZERO for 11.
REQ-020 SHALL ignore start and mode while busy=1.
REQ-021 SHALL drive j=k=0 (hold) in IDLE and DONE.
REQ-022 SHALL, in RUN with q_fb != captured limit and stop=0, drive j[i]=k[i]=1 for count up exactly when q_fb[i-1:0] are all 1; bit 0 always toggles.
REQ-023 SHALL, in RUN with q_fb != captured limit and stop=0, drive j[i]=k[i]=1 for count down exactly when q_fb[i-1:0] are all 0; bit 0 always toggles.
REQ-024 SHALL apply modulo 2^WIDTH wrap-around in RUN (up: all-ones to 0; down: 0 to all-ones).
REQ-025 SHALL increment steps by 1 on each RUN edge where a count step is driven.
REQ-026 SHALL, in RUN with q_fb == captured limit or stop=1, drive j=k=0 and go to DONE on the next edge.
REQ-027 SHALL, when q_fb already equals limit at RUN entry, take zero steps: steps=0.
REQ-028 SHALL, in LOAD for one cycle, drive j=captured load_val and k=~captured load_val, then go to DONE.
REQ-029 SHALL, in ZERO for one cycle, drive j=0 and k=all-ones, then go to DONE.
REQ-030 SHALL assert done=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-031 SHALL accept a new start in the first IDLE cycle after DONE.
REQ-032 SHALL hold steps stable from DONE until the next accepted start.
REQ-033 SHALL, when stop=1 outside RUN, take no action.
REQ-034 SHALL register busy and done.
REQ-035 SHALL make busy and done change only on clk edges.

Reset
REQ-036 SHALL, on clear=1 at a clock edge, force state IDLE.
REQ-037 SHALL, on clear=1 at a clock edge, zero all captured registers and steps.
REQ-038 SHALL, on clear=1 at a clock edge, force busy=0 and done=0.
REQ-039 SHALL drive j=k=0 from the cycle after clear is sampled.
REQ-040 SHALL give clear priority over start, stop and every state transition, including mid-RUN, mid-LOAD and in DONE.
REQ-041 SHALL drop a command interrupted by clear with no done pulse.
REQ-042 SHALL leave the bank contents to the bank's own clear/preset; clear does not modify them.

Verification
REQ-043 SHALL cover: bank=3, mode=00, limit=7, start -> four step cycles, bank reaches 7, done pulse, steps=4, bank holds 7.
REQ-044 SHALL cover: bank=1, mode=01, limit=14 (WIDTH=4) -> bank goes 1,0,15,14, steps=3, done pulse, wrap verified.
REQ-045 SHALL cover: mode=10, load_val=0xA -> one LOAD cycle with j=1010 and k=0101, bank=0xA, done 2 cycles after start edge.
REQ-046 SHALL cover: bank=5, mode=00, limit=5 -> no step, bank stays 5, steps=0, done 2 cycles after start edge.
REQ-047 SHALL cover: counting 0 to 15, stop=1 when bank=6 -> j=k=0 that cycle, bank holds 6, steps=6, done pulse.
REQ-048 SHALL cover: clear=1 mid-RUN with start=1 simultaneously -> IDLE next cycle, busy=0, done never pulses, steps=0, j=k=0.
